// File: rtl/rx_decimal_parser_pkg.sv
// Shared constants, state encoding and helpers for the UART receive-side decimal command parser.
package rx_decimal_parser_pkg;

    localparam logic [7:0] ASCII_LF    = 8'd10;
    localparam logic [7:0] ASCII_CR    = 8'd13;
    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_MINUS = 8'd45;
    localparam logic [7:0] ASCII_ZERO  = 8'd48;
    localparam logic [7:0] ASCII_NINE  = 8'd57;

    localparam int LIM_POS = 127;
    localparam int LIM_NEG = 128;
    localparam int ACC_W   = 10;

    typedef enum logic [1:0] {
        FIELD_A  = 2'd0,
        FIELD_B  = 2'd1,
        FIELD_OP = 2'd2,
        HOLD     = 2'd3
    } state_t;

    function automatic logic is_digit_char(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/rx_decimal_parser_if.sv
// Byte-in / command-out bundle between the UART receiver, the parser and the transmit-side handshake.
interface rx_decimal_parser_if #(
    parameter int DBIT = 8,
    parameter int OPW  = 6
);
    logic                   rx_done_tick;
    logic [DBIT-1:0]        dout;
    logic                   rd;
    logic signed [DBIT-1:0] a;
    logic signed [DBIT-1:0] b;
    logic [OPW-1:0]         op;
    logic                   done;
    logic                   err;

    modport master (output rx_done_tick, dout, rd, input a, b, op, done, err);
    modport slave  (input rx_done_tick, dout, rd, output a, b, op, done, err);
endinterface

// File: rtl/rx_decimal_parser_dec_accum.sv
// Decimal field accumulator: digit/sign collection with per-digit magnitude and length limits.
module rx_decimal_parser_dec_accum
    import rx_decimal_parser_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OPW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            strobe,
    input  logic [DBIT-1:0] data,
    input  logic            clear,
    input  logic            signed_mode,
    output logic [DBIT-1:0] value_ab,
    output logic [OPW-1:0]  value_op,
    output logic            error,
    output logic            empty
);

    localparam int XW = ACC_W + 4;

    logic [ACC_W-1:0] acc;
    logic             sign;
    logic [1:0]       count;

    logic [XW-1:0]    acc_next;
    logic [XW-1:0]    limit;
    logic [1:0]       max_count;
    logic             is_digit;
    logic             is_minus;
    logic             digit_err;
    logic             minus_err;
    logic [DBIT-1:0]  mag;

    // Limits are judged on the post-update value; the wide temporary keeps 128*10+9 from wrapping.
    always_comb begin
        is_digit  = is_digit_char(data);
        is_minus  = (data == ASCII_MINUS);
        acc_next  = XW'(acc) * XW'(10) + XW'(data[3:0]);
        limit     = signed_mode ? (sign ? XW'(LIM_NEG) : XW'(LIM_POS)) : XW'((1 << OPW) - 1);
        max_count = signed_mode ? 2'd3 : 2'd2;
        digit_err = (acc_next > limit) || (count == max_count);
        minus_err = !signed_mode || (count != 2'd0) || sign;
        error     = strobe && ((is_digit && digit_err) || (is_minus && minus_err));
        empty     = (count == 2'd0);
        mag       = acc[DBIT-1:0];
        value_ab  = sign ? -mag : mag;
        value_op  = acc[OPW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            sign  <= 1'b0;
            count <= 2'd0;
        end else if (clear) begin
            acc   <= '0;
            sign  <= 1'b0;
            count <= 2'd0;
        end else if (strobe && !error) begin
            if (is_digit) begin
                acc   <= acc_next[ACC_W-1:0];
                count <= count + 2'd1;
            end else if (is_minus) begin
                sign <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_decimal_parser.sv
// Sequences the A/B/OP decimal fields, registers the ALU operands and holds them until rd.
module rx_decimal_parser
    import rx_decimal_parser_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OPW  = 6
) (
    input logic               clk,
    input logic               reset,
    rx_decimal_parser_if.slave bus
);

    state_t          state;
    state_t          state_next;
    logic [DBIT-1:0] a_q;
    logic [DBIT-1:0] b_q;
    logic [OPW-1:0]  op_q;
    logic            err_q;

    logic            acc_strobe;
    logic            acc_clear;
    logic            signed_mode;
    logic [DBIT-1:0] acc_value_ab;
    logic [OPW-1:0]  acc_value_op;
    logic            acc_err;
    logic            acc_empty;
    logic            err_now;
    logic            load_a;
    logic            load_b;
    logic            load_op;

    rx_decimal_parser_dec_accum #(
        .DBIT (DBIT),
        .OPW  (OPW)
    ) u_accum (
        .clk         (clk),
        .reset       (reset),
        .strobe      (acc_strobe),
        .data        (bus.dout),
        .clear       (acc_clear),
        .signed_mode (signed_mode),
        .value_ab    (acc_value_ab),
        .value_op    (acc_value_op),
        .error       (acc_err),
        .empty       (acc_empty)
    );

    // In HOLD every byte is dropped; rd alone decides when parsing resumes, even alongside a strobe.
    always_comb begin
        state_next  = state;
        acc_clear   = 1'b0;
        err_now     = 1'b0;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_op     = 1'b0;
        acc_strobe  = bus.rx_done_tick && (state != HOLD);
        signed_mode = (state != FIELD_OP);
        case (state)
            HOLD: begin
                if (bus.rd) state_next = FIELD_A;
            end
            default: begin
                if (bus.rx_done_tick) begin
                    if (is_digit_char(bus.dout) || bus.dout == ASCII_MINUS) begin
                        err_now = acc_err;
                    end else if (bus.dout == ASCII_CR) begin
                        if (acc_empty) begin
                            err_now = 1'b1;
                        end else begin
                            acc_clear = 1'b1;
                            case (state)
                                FIELD_A: begin load_a  = 1'b1; state_next = FIELD_B;  end
                                FIELD_B: begin load_b  = 1'b1; state_next = FIELD_OP; end
                                default: begin load_op = 1'b1; state_next = HOLD;     end
                            endcase
                        end
                    end else if (bus.dout != ASCII_LF && bus.dout != ASCII_SPACE) begin
                        err_now = 1'b1;
                    end
                    if (err_now) begin
                        acc_clear  = 1'b1;
                        state_next = FIELD_A;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FIELD_A;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= err_now;
            if (load_a)  a_q  <= acc_value_ab;
            if (load_b)  b_q  <= acc_value_ab;
            if (load_op) op_q <= acc_value_op;
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign bus.op   = op_q;
    assign bus.err  = err_q;
    assign bus.done = (state == HOLD);

endmodule
